mem_ctrl: RTL and testbench

Memory controller that serves the instruction-fetch and memory-access stages over the byte-wide, single-port RAM. It arbitrates the two requesters and sequences 1, 2 or 4 single-byte RAM cycles per request. It assembles or splits little-endian words and returns a one-cycle ready pulse with the data. It sits between the pipeline stages and the RAM port: fetch and memory stages drive read/write requests and monitor `busy`, and `mem_ctrl` alone drives the RAM.

---
 rtl/mem_ctrl_if.sv | 40 ++++
 rtl/mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Request, response and RAM port bundle for mem_ctrl.
// slave is the controller's view; master is the stages-plus-RAM view.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_read;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [31:0]           if_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_width;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport slave (
    input  if_read, if_addr,
    input  mem_read, mem_write, mem_addr,
    input  mem_width, mem_wdata, ram_din,
    output if_ready, if_data, mem_ready,
    output mem_rdata, busy,
    output ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_read, if_addr,
    output mem_read, mem_write, mem_addr,
    output mem_width, mem_wdata, ram_din,
    input  if_ready, if_data, mem_ready,
    input  mem_rdata, busy,
    input  ram_a, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller arbitrating fetch and memory stages.
// Sequences 1/2/4 byte cycles and assembles little-endian words.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] base, ram_a, nxt_a;
  logic [2:0]  n, k, mem_n;
  logic [1:0]  rl, wl;
  logic [31:0] wdata, rbuf, rbuf_n;
  logic [31:0] if_data, mem_rdata;
  logic [7:0]  ram_dout;
  logic        own_mem, ram_wr;
  logic        if_ready, mem_ready;

  assign bus.if_ready  = if_ready;
  assign bus.if_data   = if_data;
  assign bus.mem_ready = mem_ready;
  assign bus.mem_rdata = mem_rdata;
  assign bus.busy      = (state != IDLE);
  assign bus.ram_a     = ram_a;
  assign bus.ram_wr    = ram_wr;
  assign bus.ram_dout  = ram_dout;

  assign nxt_a = base + ADDR_WIDTH'(k)
               + ADDR_WIDTH'(1);
  assign rl    = k[1:0] - 2'd1;
  assign wl    = k[1:0] + 2'd1;
  assign mem_n = (bus.mem_width == 2'd0) ? 3'd1
               : (bus.mem_width == 2'd1) ? 3'd2
               : 3'd4;

  always_comb begin
    state_n = state;
    rbuf_n  = rbuf;
    unique case (state)
      IDLE: begin
        if (bus.mem_write)
          state_n = WRITE;
        else if (bus.mem_read || bus.if_read)
          state_n = READ;
      end
      READ: begin
        // byte for address index k-1 arrives while k is driven
        if (k != 3'd0)
          rbuf_n[{rl, 3'b000} +: 8] = bus.ram_din;
        if (k == n)
          state_n = DONE;
      end
      WRITE: begin
        if (k == n - 3'd1)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      n         <= 3'd0;
      k         <= 3'd0;
      wdata     <= '0;
      rbuf      <= '0;
      own_mem   <= 1'b0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          k    <= 3'd0;
          rbuf <= '0;
          if (bus.mem_write || bus.mem_read) begin
            base     <= bus.mem_addr;
            ram_a    <= bus.mem_addr;
            n        <= mem_n;
            wdata    <= bus.mem_wdata;
            own_mem  <= 1'b1;
            ram_wr   <= bus.mem_write;
            ram_dout <= bus.mem_write ?
                        bus.mem_wdata[7:0] : ram_dout;
          end else if (bus.if_read) begin
            base    <= bus.if_addr;
            ram_a   <= bus.if_addr;
            n       <= 3'd4;
            own_mem <= 1'b0;
          end
        end
        READ: begin
          rbuf <= rbuf_n;
          k    <= k + 3'd1;
          if ((k + 3'd1) < n)
            ram_a <= nxt_a;
          if (state_n == DONE) begin
            if (own_mem) begin
              mem_ready <= 1'b1;
              mem_rdata <= rbuf_n;
            end else begin
              if_ready <= 1'b1;
              if_data  <= rbuf_n;
            end
          end
        end
        WRITE: begin
          if (state_n == DONE) begin
            ram_wr    <= 1'b0;
            mem_ready <= 1'b1;
          end else begin
            k        <= k + 3'd1;
            ram_a    <= nxt_a;
            ram_dout <= wdata[{wl, 3'b000} +: 8];
          end
        end
        DONE: begin
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed-vector bench for mem_ctrl with a 1 KiB byte RAM model.
// Vectors carry hand-computed data and ready cycles.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(32)) b ();

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(b.slave)
  );

  logic [7:0] ram [1024];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13;
    ram[10'h010] = 8'h34;
    ram[10'h011] = 8'h12;
    ram[10'h3FE] = 8'h11;
    ram[10'h3FF] = 8'h22;
    ram[10'h000] = 8'h33;
    ram[10'h001] = 8'h44;
    b.ram_din = 8'h00;
    forever begin
      @(posedge clk);
      if (b.ram_wr) ram[b.ram_a[9:0]] = b.ram_dout;
      b.ram_din <= ram[b.ram_a[9:0]];
    end
  end

  typedef struct {
    logic        fetch;
    logic        rd;
    logic        wr;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          rdy;
  } vec_t;

  vec_t vecs [11];
  logic [31:0] last_if, last_mem;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    b.if_read   = 1'b0;
    b.mem_read  = 1'b0;
    b.mem_write = 1'b0;
  endtask

  task automatic run(input int id, input vec_t v);
    int n, rc, rcnt, ocnt;
    logic own;
    logic [31:0] wd;
    logic bz [16];
    own = v.rd | v.wr;
    n = v.fetch ? 4 : (v.width == 2'd0) ? 1
      : (v.width == 2'd1) ? 2 : 4;
    b.if_read   = v.fetch;
    b.if_addr   = v.addr;
    b.mem_read  = v.rd;
    b.mem_write = v.wr;
    b.mem_addr  = v.addr;
    b.mem_width = v.width;
    b.mem_wdata = v.wdata;
    @(posedge clk); #1;
    idle_inputs();
    b.if_addr   = ~v.addr;
    b.mem_addr  = ~v.addr;
    b.mem_wdata = ~v.wdata;
    rc = 0; rcnt = 0; ocnt = 0;
    wd = v.wdata;
    for (int c = 1; c < 16; c++) begin
      bz[c] = b.busy;
      if (c <= n) begin
        chk($sformatf("v%0d ram_a c%0d", id, c),
            b.ram_a, v.addr + 32'(c - 1));
        chk($sformatf("v%0d ram_wr c%0d", id, c),
            32'(b.ram_wr), 32'(v.wr));
        if (v.wr) begin
          chk($sformatf("v%0d ram_dout c%0d", id, c),
              32'(b.ram_dout), 32'(wd[7:0]));
          wd = wd >> 8;
        end
      end
      if ((own ? b.mem_ready : b.if_ready) === 1'b1) begin
        rcnt++;
        if (rc == 0) rc = c;
        if (!v.wr)
          chk($sformatf("v%0d data", id),
              own ? b.mem_rdata : b.if_data, v.exp);
      end
      if ((own ? b.if_ready : b.mem_ready) === 1'b1)
        ocnt++;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d ready cycle", id), rc, v.rdy);
    chk($sformatf("v%0d ready pulses", id), rcnt, 1);
    chk($sformatf("v%0d other ready", id), ocnt, 0);
    chk($sformatf("v%0d busy c1", id), 32'(bz[1]), 1);
    if (v.rdy > 0 && v.rdy < 15)
      chk($sformatf("v%0d busy after", id),
          32'(bz[v.rdy + 1]), 0);
    if (!v.wr) begin
      if (own) last_mem = v.exp;
      else     last_if  = v.exp;
    end
    chk($sformatf("v%0d if_data hold", id),
        b.if_data, last_if);
    chk($sformatf("v%0d mem_rdata hold", id),
        b.mem_rdata, last_mem);
  endtask

  initial begin
    int mc, ic;
    // fetch, rd, wr, width, addr, wdata, exp, ready cycle
    vecs[0]  = '{1, 0, 0, 2'd2, 32'h100, 0, 32'h00000013, 6};
    vecs[1]  = '{0, 0, 1, 2'd2, 32'h200, 32'hDEADBEEF, 0, 5};
    vecs[2]  = '{0, 1, 0, 2'd0, 32'h202, 0, 32'h000000AD, 3};
    vecs[3]  = '{0, 1, 0, 2'd1, 32'h010, 0, 32'h00001234, 4};
    vecs[4]  = '{0, 1, 0, 2'd1, 32'h201, 0, 32'h0000ADBE, 4};
    vecs[5]  = '{0, 1, 0, 2'd3, 32'h200, 0, 32'hDEADBEEF, 6};
    vecs[6]  = '{0, 0, 1, 2'd0, 32'h300, 32'h1234565A, 0, 2};
    vecs[7]  = '{0, 1, 0, 2'd1, 32'h300, 0, 32'h0000005A, 4};
    vecs[8]  = '{0, 1, 1, 2'd1, 32'h304, 32'hFFFFA5C3, 0, 3};
    vecs[9]  = '{0, 1, 0, 2'd2, 32'h304, 0, 32'h0000A5C3, 6};
    vecs[10] = '{0, 1, 0, 2'd2, 32'hFFFFFFFE, 0,
                 32'h44332211, 6};
    last_if = 0;
    last_mem = 0;
    idle_inputs();
    b.if_addr = 0; b.mem_addr = 0;
    b.mem_width = 0; b.mem_wdata = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(b.busy), 0);
    chk("rst if_ready", 32'(b.if_ready), 0);
    chk("rst mem_ready", 32'(b.mem_ready), 0);
    chk("rst ram_wr", 32'(b.ram_wr), 0);
    chk("rst ram_a", b.ram_a, 0);
    chk("rst ram_dout", 32'(b.ram_dout), 0);
    chk("rst if_data", b.if_data, 0);
    chk("rst mem_rdata", b.mem_rdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run(i, vecs[i]);

    // both requesters together: MEM wins, fetch follows
    b.if_read = 1'b1;  b.if_addr = 32'h100;
    b.mem_read = 1'b1; b.mem_addr = 32'h010;
    b.mem_width = 2'd1;
    @(posedge clk); #1;
    b.mem_read = 1'b0;
    mc = 0; ic = 0;
    for (int c = 1; c < 20; c++) begin
      if (b.mem_ready === 1'b1 && mc == 0) begin
        mc = c;
        chk("arb mem_rdata", b.mem_rdata, 32'h00001234);
      end
      if (b.if_ready === 1'b1 && ic == 0) begin
        ic = c;
        b.if_read = 1'b0;
        chk("arb if_data", b.if_data, 32'h00000013);
      end
      @(posedge clk); #1;
    end
    b.if_read = 1'b0;
    chk("arb mem cycle", mc, 4);
    chk("arb if cycle", ic, 11);
    chk("arb idle", 32'(b.busy), 0);
    last_mem = 32'h00001234;

    // reset during cycle 2 of a word write
    b.mem_write = 1'b1; b.mem_addr = 32'h380;
    b.mem_width = 2'd2; b.mem_wdata = 32'h01020304;
    @(posedge clk); #1;
    b.mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid busy", 32'(b.busy), 0);
    chk("mid ram_wr", 32'(b.ram_wr), 0);
    chk("mid if_ready", 32'(b.if_ready), 0);
    chk("mid mem_ready", 32'(b.mem_ready), 0);
    chk("mid ram_a", b.ram_a, 0);
    chk("mid if_data", b.if_data, 0);
    chk("mid mem_rdata", b.mem_rdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid byte0", 32'(ram[10'h380]), 32'h04);
    chk("mid byte1", 32'(ram[10'h381]), 32'h03);
    chk("mid byte2", 32'(ram[10'h382]), 32'h00);
    last_if = 0;
    last_mem = 0;
    run(11, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
